// File: rtl/calc_sequencer_if.sv
// Bundle of the command, calculator and display signals around calc_sequencer.
//   cmd_*   : parser -> sequencer command strobe and payload
//   calc_*  : sequencer <-> calculator start/operands and done/result
//   disp_*  : sequencer <-> LCD driver display registers and req/ack
//   busy, overflow, q_count : sequencer status
// modport slave is the sequencer's view; modport master is the surrounding logic.
interface calc_sequencer_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned QW = $clog2(DEPTH) + 1;

    logic          cmd_valid;
    logic [7:0]    cmd_op1;
    logic [7:0]    cmd_op2;
    logic [7:0]    cmd_opr;

    logic          calc_start;
    logic [7:0]    calc_a;
    logic [7:0]    calc_b;
    logic [7:0]    calc_opr;
    logic          calc_done;
    logic [7:0]    calc_result;

    logic [7:0]    disp_num1;
    logic [7:0]    disp_num2;
    logic [7:0]    disp_opr;
    logic [7:0]    disp_result;
    logic          disp_err;
    logic          disp_req;
    logic          disp_ack;

    logic          busy;
    logic          overflow;
    logic [QW-1:0] q_count;

    modport slave (
        input  cmd_valid, cmd_op1, cmd_op2, cmd_opr,
        output calc_start, calc_a, calc_b, calc_opr,
        input  calc_done, calc_result,
        output disp_num1, disp_num2, disp_opr, disp_result, disp_err, disp_req,
        input  disp_ack,
        output busy, overflow, q_count
    );

    modport master (
        output cmd_valid, cmd_op1, cmd_op2, cmd_opr,
        input  calc_start, calc_a, calc_b, calc_opr,
        output calc_done, calc_result,
        input  disp_num1, disp_num2, disp_opr, disp_result, disp_err, disp_req,
        output disp_ack,
        input  busy, overflow, q_count
    );
endinterface

// File: rtl/calc_sequencer.sv
// Sequencer between command parser, calculator and LCD driver.
// Queues parsed commands in a DEPTH-entry FIFO, issues each to the calculator,
// waits for calc_done (bounded by TIMEOUT cycles), then latches the job into
// stable display registers and holds disp_req until the LCD driver acks.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : calc_sequencer_if.slave (command in, calculator, display, status)
module calc_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    calc_sequencer_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned QW = AW + 1;
    localparam int unsigned TW = 16;

    typedef struct packed {
        logic [7:0] op1;
        logic [7:0] op2;
        logic [7:0] opr;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CALC, UPDATE} state_t;

    state_t        state;
    state_t        state_nxt;
    cmd_t          fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [QW-1:0] count;
    logic [QW-1:0] count_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          full;
    logic          push;
    logic          pop;
    logic          tmo_hit;

    // The head is consumed during the single ISSUE cycle, so a full FIFO can still accept then.
    assign full         = (count == QW'(DEPTH));
    assign pop          = (state == ISSUE);
    assign push         = bus.cmd_valid && (!full || pop);
    assign bus.overflow = bus.cmd_valid && full && !pop;
    assign bus.q_count  = count;

    // Last WAIT_CALC cycle: the counter reaches TIMEOUT at the end of this cycle.
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + QW'(1);
        end else if (pop && !push) begin
            count_nxt = count - QW'(1);
        end
    end

    // Next-state logic; calc_done wins over a simultaneous timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (count != '0) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_CALC;
            WAIT_CALC: if (bus.calc_done || tmo_hit) state_nxt = UPDATE;
            UPDATE:    if (bus.disp_ack) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{op1: bus.cmd_op1, op2: bus.cmd_op2, opr: bus.cmd_opr};
        end
    end

    // State, pointers and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            tmo_cnt         <= '0;
            bus.calc_start  <= 1'b0;
            bus.calc_a      <= '0;
            bus.calc_b      <= '0;
            bus.calc_opr    <= '0;
            bus.disp_num1   <= '0;
            bus.disp_num2   <= '0;
            bus.disp_opr    <= '0;
            bus.disp_result <= '0;
            bus.disp_err    <= 1'b0;
            bus.disp_req    <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            // Operands are loaded on ISSUE entry and held until the next issue.
            bus.calc_start <= (state_nxt == ISSUE);
            if (state_nxt == ISSUE) begin
                {bus.calc_a, bus.calc_b, bus.calc_opr} <= fifo_mem[rd_ptr];
            end

            tmo_cnt <= (state == WAIT_CALC) ? tmo_cnt + TW'(1) : '0;

            // Display registers change only on UPDATE entry, never while disp_req is high.
            if (state == WAIT_CALC && state_nxt == UPDATE) begin
                bus.disp_num1   <= bus.calc_a;
                bus.disp_num2   <= bus.calc_b;
                bus.disp_opr    <= bus.calc_opr;
                bus.disp_result <= bus.calc_done ? bus.calc_result : 8'h00;
                bus.disp_err    <= !bus.calc_done;
            end

            bus.disp_req <= (state_nxt == UPDATE);
            bus.busy     <= (state_nxt != IDLE) || (count_nxt != '0);
        end
    end
endmodule
